// File: rtl/imm_encoder.sv
// Packs a 64-bit immediate plus register fields into LEGv8 instruction words.
// Wide constants (MOVZ class) are split into a MOVZ/MOVK sequence, one word per handshake.
module imm_encoder #(
  parameter logic [8:0] MOVZ_OP = 9'b110100101,
  parameter logic [8:0] MOVK_OP = 9'b111100101
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        InValid,
  output logic        InReady,
  input  logic [63:0] Value,
  input  logic [2:0]  Ctrl,
  input  logic [10:0] Op,
  input  logic [4:0]  Rn,
  input  logic [4:0]  Rd,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [31:0] Instr,
  output logic        Last,
  output logic        Err
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t      r_state;
  logic [63:0] r_value;
  logic [4:0]  r_rd;
  logic [3:0]  r_rem;
  logic        r_inReady;
  logic        r_outValid;
  logic [31:0] r_instr;
  logic        r_last;
  logic        r_err;

  logic [3:0]  w_inMask;
  logic [1:0]  w_firstIdx;
  logic [3:0]  w_firstRem;
  logic [31:0] w_firstInstr;
  logic        w_legal;
  logic        w_firstErr;
  logic        w_firstLast;
  logic [1:0]  w_nextIdx;
  logic [3:0]  w_nextRem;
  logic [31:0] w_nextInstr;
  logic        w_nextLast;

  // Lowest set bit wins; an empty mask maps to halfword 0 so Value=0 still yields MOVZ hw=0.
  function automatic logic [1:0] lowestIdx(input logic [3:0] m);
    logic [1:0] idx;
    idx = 2'd0;
    if (m[3]) idx = 2'd3;
    if (m[2]) idx = 2'd2;
    if (m[1]) idx = 2'd1;
    if (m[0]) idx = 2'd0;
    return idx;
  endfunction

  function automatic logic [15:0] halfword(input logic [63:0] v, input logic [1:0] idx);
    return v[{idx, 4'b0000} +: 16];
  endfunction

  function automatic logic [31:0] wideWord(input logic [8:0] opc, input logic [1:0] idx,
                                           input logic [15:0] hw, input logic [4:0] rd);
    return {opc, idx, hw, rd};
  endfunction

  always_comb begin
    for (int i = 0; i < 4; i++) w_inMask[i] = |Value[16*i +: 16];
    w_firstIdx   = lowestIdx(w_inMask);
    w_firstRem   = 4'd0;
    w_legal      = 1'b0;
    w_firstInstr = 32'd0;
    case (Ctrl)
      3'd0: begin
        w_legal      = (Value[63:8] == {56{Value[8]}});
        w_firstInstr = {Op, Value[8:0], 2'b00, Rn, Rd};
      end
      3'd1: begin
        w_legal      = (Value[1:0] == 2'b00) && (Value[63:20] == {44{Value[20]}});
        w_firstInstr = {Op[10:3], Value[20:2], Rd};
      end
      3'd2: begin
        w_legal      = (Value[1:0] == 2'b00) && (Value[63:27] == {37{Value[27]}});
        w_firstInstr = {Op[10:5], Value[27:2]};
      end
      3'd3: begin
        w_legal      = (Value[63:12] == 52'd0);
        w_firstInstr = {Op[10:1], Value[11:0], Rn, Rd};
      end
      3'd4: begin
        w_legal      = 1'b1;
        w_firstInstr = wideWord(MOVZ_OP, w_firstIdx, halfword(Value, w_firstIdx), Rd);
        w_firstRem   = w_inMask & ~(4'b0001 << w_firstIdx);
      end
      default: w_legal = 1'b0;
    endcase
    if (!w_legal) w_firstInstr = 32'd0;
    w_firstErr  = !w_legal;
    w_firstLast = (w_firstRem == 4'd0);
  end

  // Follow-on words come from the halfwords still pending in r_rem.
  always_comb begin
    w_nextIdx   = lowestIdx(r_rem);
    w_nextInstr = wideWord(MOVK_OP, w_nextIdx, halfword(r_value, w_nextIdx), r_rd);
    w_nextRem   = r_rem & ~(4'b0001 << w_nextIdx);
    w_nextLast  = (w_nextRem == 4'd0);
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
      r_instr    <= 32'd0;
      r_last     <= 1'b0;
      r_err      <= 1'b0;
      r_rem      <= 4'd0;
      r_value    <= 64'd0;
      r_rd       <= 5'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (InValid && r_inReady) begin
            r_value    <= Value;
            r_rd       <= Rd;
            r_rem      <= w_firstRem;
            r_instr    <= w_firstInstr;
            r_last     <= w_firstLast;
            r_err      <= w_firstErr;
            r_outValid <= 1'b1;
            r_inReady  <= 1'b0;
            r_state    <= EMIT;
          end
        end
        EMIT: begin
          if (OutReady) begin
            if (r_last) begin
              r_outValid <= 1'b0;
              r_inReady  <= 1'b1;
              r_state    <= IDLE;
            end else begin
              r_instr <= w_nextInstr;
              r_last  <= w_nextLast;
              r_rem   <= w_nextRem;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign InReady  = r_inReady;
  assign OutValid = r_outValid;
  assign Instr    = r_instr;
  assign Last     = r_last;
  assign Err      = r_err;

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed scenarios plus randomized requests
// compared against an arithmetic reference model.
module tb_imm_encoder;

  typedef struct packed {
    logic [31:0] instr;
    logic        last;
    logic        err;
  } word_t;

  logic        CLK;
  logic        Reset;
  logic        InValid;
  logic        InReady;
  logic [63:0] Value;
  logic [2:0]  Ctrl;
  logic [10:0] Op;
  logic [4:0]  Rn;
  logic [4:0]  Rd;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] Instr;
  logic        Last;
  logic        Err;

  int    checkCount = 0;
  int    passCount  = 0;
  word_t obsQ[$];
  word_t expQ[$];
  int    stableErrors;
  bit    timedOut;
  bit    firstValidOk;
  bit    endIdleOk;

  imm_encoder dut (
    .CLK(CLK), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .Value(Value), .Ctrl(Ctrl), .Op(Op), .Rn(Rn), .Rd(Rd),
    .OutValid(OutValid), .OutReady(OutReady), .Instr(Instr), .Last(Last), .Err(Err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Reference model: field placement by multiplication, legality by signed range.
  function automatic void refModel(input logic [2:0] ctrl, input logic [63:0] value,
                                   input logic [10:0] op, input logic [4:0] rn, input logic [4:0] rd);
    longint sv, lop, lrn, lrd, lh, w;
    bit ok, first;
    sv = $signed(value);
    lop = op; lrn = rn; lrd = rd;
    ok = 0; w = 0; first = 1;
    expQ.delete();
    case (ctrl)
      3'd0: begin
        ok = (sv >= -256) && (sv <= 255);
        w = lop * 2097152 + (sv & 511) * 4096 + lrn * 32 + lrd;
      end
      3'd1: begin
        ok = (value % 4 == 0) && (sv >= -1048576) && (sv <= 1048575);
        w = (lop / 8) * 16777216 + ((sv / 4) & 524287) * 32 + lrd;
      end
      3'd2: begin
        ok = (value % 4 == 0) && (sv >= -134217728) && (sv <= 134217727);
        w = (lop / 32) * 67108864 + ((sv / 4) & 67108863);
      end
      3'd3: begin
        ok = (value < 4096);
        w = (lop / 2) * 4194304 + (sv & 4095) * 1024 + lrn * 32 + lrd;
      end
      3'd4: begin
        for (int k = 0; k < 4; k++) begin
          lh = longint'((value >> (16 * k)) & 64'hFFFF);
          if (lh != 0) begin
            expQ.push_back({32'((first ? 421 : 485) * 8388608 + k * 2097152 + lh * 32 + lrd), 1'b0, 1'b0});
            first = 0;
          end
        end
        if (expQ.size() == 0) expQ.push_back({32'(421 * 8388608 + lrd), 1'b0, 1'b0});
        expQ[expQ.size() - 1].last = 1'b1;
        return;
      end
      default: ok = 0;
    endcase
    if (ok) expQ.push_back({32'(w), 1'b1, 1'b0});
    else    expQ.push_back({32'd0, 1'b1, 1'b1});
  endfunction

  function automatic logic [63:0] randValue();
    longint t;
    logic [63:0] v;
    case ($urandom_range(0, 4))
      0: return {$urandom, $urandom};
      1: begin t = $signed($urandom); t = t >>> $urandom_range(4, 31); return t; end
      2: return 64'($urandom_range(0, 8191));
      3: begin
        v = 64'd0;
        for (int k = 0; k < 4; k++)
          if ($urandom_range(0, 1) == 1) v = v | (64'($urandom & 32'hFFFF) << (16 * k));
        return v;
      end
      default: begin t = $signed($urandom); t = t >>> $urandom_range(2, 31); return t & ~64'd3; end
    endcase
  endfunction

  // Drives one request and collects every emitted word, stalling each word for `stall` cycles.
  task automatic applyStimulus(input logic [2:0] ctrl, input logic [63:0] value, input logic [10:0] op,
                               input logic [4:0] rn, input logic [4:0] rd, input int stall);
    word_t snap;
    int    guard;
    bit    done;
    obsQ.delete();
    stableErrors = 0; done = 0; guard = 0;
    while (InReady !== 1'b1 && guard < 20) begin @(posedge CLK); #1; guard++; end
    Ctrl = ctrl; Value = value; Op = op; Rn = rn; Rd = rd; InValid = 1'b1;
    @(posedge CLK); #1;
    InValid = 1'b0;
    Value = {$urandom, $urandom}; Ctrl = 3'($urandom); Op = 11'($urandom); Rn = 5'($urandom); Rd = 5'($urandom);
    firstValidOk = (OutValid === 1'b1);
    guard = 0;
    while (!done && guard < 40) begin
      if (OutValid === 1'b1) begin
        snap = {Instr, Last, Err};
        for (int s = 0; s < stall; s++) begin
          OutReady = 1'b0;
          @(posedge CLK); #1;
          if (OutValid !== 1'b1 || {Instr, Last, Err} !== snap) stableErrors++;
        end
        obsQ.push_back(snap);
        OutReady = 1'b1;
        @(posedge CLK); #1;
        OutReady = 1'b0;
        if (snap.last) done = 1;
      end else begin
        @(posedge CLK); #1;
      end
      guard++;
    end
    timedOut  = !done;
    endIdleOk = (OutValid === 1'b0) && (InReady === 1'b1);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    checkCount++;
    if ({InReady, OutValid, Instr, Last, Err} !== {1'b1, 1'b0, 32'd0, 1'b0, 1'b0})
      $display("[TB] FAIL reset_values got %h want %h", {InReady, OutValid, Instr, Last, Err}, {1'b1, 1'b0, 32'd0, 1'b0, 1'b0});
    else passCount++;
    Reset = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_itype();
    applyStimulus(3'd3, 64'h123, 11'h488, 5'd2, 5'd3, 0);
    checkCount++;
    if (!firstValidOk) $display("[TB] FAIL itype_latency got OutValid=%b want 1", OutValid);
    else passCount++;
    checkCount++;
    if (obsQ.size() != 1 || obsQ[0] !== {32'h91048C43, 1'b1, 1'b0})
      $display("[TB] FAIL itype_word got n=%0d %h want %h", obsQ.size(), obsQ[0], {32'h91048C43, 1'b1, 1'b0});
    else passCount++;
    checkCount++;
    if (!endIdleOk) $display("[TB] FAIL itype_return_idle got OutValid=%b InReady=%b want 0/1", OutValid, InReady);
    else passCount++;
  endtask

  task automatic test_movz_split();
    applyStimulus(3'd4, 64'h0000_1234_0000_5678, 11'h0, 5'd0, 5'd9, 0);
    checkCount++;
    if (obsQ.size() != 2) $display("[TB] FAIL movz_count got %0d want 2", obsQ.size());
    else passCount++;
    checkCount++;
    if (obsQ[0] !== {32'hD28ACF09, 1'b0, 1'b0}) $display("[TB] FAIL movz_word0 got %h want %h", obsQ[0], {32'hD28ACF09, 1'b0, 1'b0});
    else passCount++;
    checkCount++;
    if (obsQ[1] !== {32'hF2C24689, 1'b1, 1'b0}) $display("[TB] FAIL movz_word1 got %h want %h", obsQ[1], {32'hF2C24689, 1'b1, 1'b0});
    else passCount++;
  endtask

  task automatic test_movz_stall();
    applyStimulus(3'd4, 64'h0000_1234_0000_5678, 11'h0, 5'd0, 5'd9, 3);
    checkCount++;
    if (stableErrors != 0) $display("[TB] FAIL movz_stall_stable got %0d changes want 0", stableErrors);
    else passCount++;
    checkCount++;
    if (obsQ.size() != 2 || obsQ[0] !== {32'hD28ACF09, 1'b0, 1'b0} || obsQ[1] !== {32'hF2C24689, 1'b1, 1'b0})
      $display("[TB] FAIL movz_stall_words got n=%0d %h %h want 2 words", obsQ.size(), obsQ[0], obsQ[1]);
    else passCount++;
    checkCount++;
    if (!endIdleOk || timedOut) $display("[TB] FAIL movz_stall_end got idle=%b timeout=%b want 1/0", endIdleOk, timedOut);
    else passCount++;
  endtask

  task automatic test_movz_zero();
    applyStimulus(3'd4, 64'd0, 11'h0, 5'd0, 5'd5, 0);
    checkCount++;
    if (obsQ.size() != 1 || obsQ[0] !== {32'hD2800005, 1'b1, 1'b0})
      $display("[TB] FAIL movz_zero got n=%0d %h want %h", obsQ.size(), obsQ[0], {32'hD2800005, 1'b1, 1'b0});
    else passCount++;
  endtask

  task automatic test_cbz();
    applyStimulus(3'd1, 64'hFFFF_FFFF_FFFF_FFF8, 11'h5A0, 5'd0, 5'd1, 0);
    checkCount++;
    if (obsQ.size() != 1 || obsQ[0] !== {32'hB4FFFFC1, 1'b1, 1'b0})
      $display("[TB] FAIL cbz_word got n=%0d %h want %h", obsQ.size(), obsQ[0], {32'hB4FFFFC1, 1'b1, 1'b0});
    else passCount++;
  endtask

  task automatic test_errors();
    logic [2:0]  ctrls[4] = '{3'd1, 3'd0, 3'd3, 3'd6};
    logic [63:0] vals[4]  = '{64'd6, 64'd256, 64'h1000, 64'd0};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(ctrls[i], vals[i], 11'h7FF, 5'd7, 5'd8, 1);
      checkCount++;
      if (obsQ.size() != 1 || obsQ[0] !== {32'd0, 1'b1, 1'b1})
        $display("[TB] FAIL error_case%0d got n=%0d %h want %h", i, obsQ.size(), obsQ[0], {32'd0, 1'b1, 1'b1});
      else passCount++;
    end
  endtask

  task automatic test_boundaries();
    logic [2:0]  ctrls[8] = '{3'd0, 3'd0, 3'd0, 3'd3, 3'd1, 3'd1, 3'd2, 3'd2};
    logic [63:0] vals[8]  = '{64'd255, -64'sd256, -64'sd257, 64'd4095,
                              64'h000F_FFFC, 64'h0010_0000, 64'h07FF_FFFC, -64'sd134217728};
    for (int i = 0; i < 8; i++) begin
      refModel(ctrls[i], vals[i], 11'h5A5, 5'd17, 5'd30);
      applyStimulus(ctrls[i], vals[i], 11'h5A5, 5'd17, 5'd30, 0);
      checkCount++;
      if (obsQ.size() != 1 || obsQ[0] !== expQ[0])
        $display("[TB] FAIL boundary%0d got n=%0d %h want %h", i, obsQ.size(), obsQ[0], expQ[0]);
      else passCount++;
    end
  endtask

  task automatic test_reset_mid_sequence();
    int guard = 0;
    refModel(3'd4, 64'hFFFF_FFFF_FFFF_FFFF, 11'h0, 5'd0, 5'd12);
    while (InReady !== 1'b1 && guard < 20) begin @(posedge CLK); #1; guard++; end
    Ctrl = 3'd4; Value = 64'hFFFF_FFFF_FFFF_FFFF; Rd = 5'd12; InValid = 1'b1;
    @(posedge CLK); #1;
    InValid = 1'b0;
    checkCount++;
    if (OutValid !== 1'b1 || {Instr, Last, Err} !== expQ[0])
      $display("[TB] FAIL midreset_word0 got %b %h want 1 %h", OutValid, {Instr, Last, Err}, expQ[0]);
    else passCount++;
    OutReady = 1'b1;
    @(posedge CLK); #1;
    checkCount++;
    if ({Instr, Last, Err} !== expQ[1]) $display("[TB] FAIL midreset_word1 got %h want %h", {Instr, Last, Err}, expQ[1]);
    else passCount++;
    @(posedge CLK); #1;
    OutReady = 1'b0;
    Reset = 1'b1;
    @(posedge CLK); #1;
    Reset = 1'b0;
    checkCount++;
    if ({InReady, OutValid, Instr, Last, Err} !== {1'b1, 1'b0, 32'd0, 1'b0, 1'b0})
      $display("[TB] FAIL midreset_state got %h want %h", {InReady, OutValid, Instr, Last, Err}, {1'b1, 1'b0, 32'd0, 1'b0, 1'b0});
    else passCount++;
  endtask

  task automatic test_after_reset();
    refModel(3'd0, -64'sd100, 11'h7C2, 5'd4, 5'd6);
    applyStimulus(3'd0, -64'sd100, 11'h7C2, 5'd4, 5'd6, 0);
    checkCount++;
    if (obsQ.size() != 1 || obsQ[0] !== expQ[0])
      $display("[TB] FAIL after_reset got n=%0d %h want %h", obsQ.size(), obsQ[0], expQ[0]);
    else passCount++;
  endtask

  task automatic test_random();
    logic [2:0]  c;
    logic [63:0] v;
    logic [10:0] o;
    logic [4:0]  n, d;
    int          bad;
    for (int r = 0; r < 60; r++) begin
      c = ($urandom_range(0, 3) == 0) ? 3'd4 : 3'($urandom_range(0, 7));
      v = randValue();
      o = 11'($urandom); n = 5'($urandom); d = 5'($urandom);
      refModel(c, v, o, n, d);
      applyStimulus(c, v, o, n, d, $urandom_range(0, 2));
      bad = (obsQ.size() != expQ.size()) || timedOut || !endIdleOk || (stableErrors != 0) || !firstValidOk;
      for (int i = 0; i < obsQ.size() && i < expQ.size(); i++)
        if (obsQ[i] !== expQ[i]) bad = 1;
      checkCount++;
      if (bad != 0)
        $display("[TB] FAIL random%0d ctrl=%0d value=%h got n=%0d first=%h want n=%0d first=%h", r, c, v,
                 obsQ.size(), obsQ[0], expQ.size(), expQ[0]);
      else passCount++;
    end
  endtask

  initial begin
    Reset = 1'b1; InValid = 1'b0; OutReady = 1'b0;
    Value = 64'd0; Ctrl = 3'd0; Op = 11'd0; Rn = 5'd0; Rd = 5'd0;
    test_reset();
    test_itype();
    test_movz_split();
    test_movz_stall();
    test_movz_zero();
    test_cbz();
    test_errors();
    test_boundaries();
    test_reset_mid_sequence();
    test_after_reset();
    test_random();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
